// File: rtl/img_frame_rx.sv
// rtl/img_frame_rx.sv - row-beat image frame receiver with consumer-side hold
//
// Collects ROWS row beats of ROW_W pixels into a shadow buffer. A complete
// frame is copied into frame_out (row 0 in the MSBs). While hold is high a
// finished frame is parked and the source is back-pressured.
// Optional feature: define IMG_RX_PARITY_EN to check even parity per beat and
// drop frames that contain any bad beat.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   row beat handshake (s_ready is registered, state only)
//   s_data            row pixels, MSB = leftmost pixel
//   s_sof             beat is row 0 of a new frame
//   s_par             even-parity bit over s_data (parity build only)
//   hold              consumer busy; frame_out frozen while high
//   frame_out         last committed frame
//   frame_upd         one-cycle pulse after frame_out changes
//   frame_cnt         committed frame count, wraps
//   err_sync          one-cycle pulse on a framing error
//   err_par           one-cycle pulse when a parity-failed frame is dropped
module img_frame_rx #(
  parameter int ROW_W = 32,
  parameter int ROWS  = 32,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ROW_W-1:0]       s_data,
  input  logic                   s_sof,
  input  logic                   s_par,
  input  logic                   hold,
  output logic [ROW_W*ROWS-1:0]  frame_out,
  output logic                   frame_upd,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   err_sync,
  output logic                   err_par
);
  localparam int FW = ROW_W * ROWS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  state_t           r_state;
  logic [RW-1:0]    r_row;
  logic [FW-1:0]    r_shadow;
  logic [FW-1:0]    r_frame;
  logic             r_ready;
  logic             r_upd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_sync;

  logic             w_acc;
  logic             w_drop;
  logic [FW-1:0]    w_full;

  assign w_acc  = s_valid && r_ready;
  // Last row lives in the LSBs, so a same-edge commit merges the beat there.
  assign w_full = {r_shadow[FW-1:ROW_W], s_data};

`ifdef IMG_RX_PARITY_EN
  logic r_bad;
  logic r_err_par;
  logic w_par_bad;
  assign w_par_bad = ^{s_data, s_par};
  assign w_drop    = r_bad | w_par_bad;
  assign err_par   = r_err_par;
`else
  logic w_unused_par;
  assign w_unused_par = s_par;
  assign w_drop       = 1'b0;
  assign err_par      = 1'b0;
`endif

  assign s_ready   = r_ready;
  assign frame_out = r_frame;
  assign frame_upd = r_upd;
  assign frame_cnt = r_cnt;
  assign err_sync  = r_err_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_shadow   <= '0;
      r_frame    <= '0;
      r_ready    <= 1'b1;
      r_upd      <= 1'b0;
      r_cnt      <= '0;
      r_err_sync <= 1'b0;
`ifdef IMG_RX_PARITY_EN
      r_bad      <= 1'b0;
      r_err_par  <= 1'b0;
`endif
    end else begin
      r_upd      <= 1'b0;
      r_err_sync <= 1'b0;
`ifdef IMG_RX_PARITY_EN
      r_err_par  <= 1'b0;
`endif
      case (r_state)
        IDLE, FILL: begin
          if (w_acc) begin
            if (s_sof) begin
              // Start (or restart) a frame; a restart mid-frame is a sync error.
              r_shadow[FW-1 -: ROW_W] <= s_data;
              r_row      <= RW'(1);
              r_state    <= FILL;
              r_err_sync <= (r_state == FILL);
`ifdef IMG_RX_PARITY_EN
              r_bad      <= w_par_bad;
`endif
            end else if (r_state == IDLE) begin
              r_err_sync <= 1'b1;
            end else begin
              r_shadow[(ROWS - 1 - int'(r_row)) * ROW_W +: ROW_W] <= s_data;
              r_row <= r_row + RW'(1);
`ifdef IMG_RX_PARITY_EN
              r_bad <= r_bad | w_par_bad;
`endif
              if (r_row == LAST_ROW) begin
                r_row <= '0;
                if (w_drop) begin
                  r_state   <= IDLE;
`ifdef IMG_RX_PARITY_EN
                  r_err_par <= 1'b1;
`endif
                end else if (hold) begin
                  r_state <= PEND;
                  r_ready <= 1'b0;
                end else begin
                  r_frame <= w_full;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_upd   <= 1'b1;
                  r_state <= IDLE;
                end
              end
            end
          end
        end
        PEND: begin
          if (!hold) begin
            r_frame <= r_shadow;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_upd   <= 1'b1;
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_img_frame_rx.sv
// tb/tb_img_frame_rx.sv - randomized self-checking bench for img_frame_rx
module tb_img_frame_rx;
  localparam int ROW_W = 32;
  localparam int ROWS  = 32;
  localparam int CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  s_valid = 1'b0;
  logic [ROW_W-1:0]      s_data = '0;
  logic                  s_sof = 1'b0;
  logic                  s_par = 1'b0;
  logic                  hold = 1'b0;
  logic                  s_ready;
  logic [ROW_W*ROWS-1:0] frame_out;
  logic                  frame_upd;
  logic [CNT_W-1:0]      frame_cnt;
  logic                  err_sync;
  logic                  err_par;

  img_frame_rx #(.ROW_W(ROW_W), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .s_par(s_par), .hold(hold),
    .frame_out(frame_out), .frame_upd(frame_upd), .frame_cnt(frame_cnt),
    .err_sync(err_sync), .err_par(err_par)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: partial frame as a queue of rows, committed frame as an array.
  logic [ROW_W-1:0] m_rows[$];
  logic [ROW_W-1:0] m_frame[ROWS];
  int  m_cnt;
  int  m_total;
  bit  m_bad;
  bit  m_pend;
  bit  e_upd, e_sync, e_par;
  bit  g_gaps;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rows.delete();
    for (int r = 0; r < ROWS; r++) m_frame[r] = '0;
    m_cnt = 0; m_bad = 0; m_pend = 0;
    e_upd = 0; e_sync = 0; e_par = 0;
  endtask

  task automatic model_commit();
    for (int r = 0; r < ROWS; r++) m_frame[r] = m_rows[r];
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_total++;
    e_upd = 1;
    m_rows.delete();
    m_pend = 0;
  endtask

  task automatic model_accept(input logic [ROW_W-1:0] d, input bit sof, input bit pbad, input bit h);
    bit drop;
    drop = 0;
    if (sof) begin
      if (m_rows.size() != 0) e_sync = 1;
      m_rows.delete();
      m_rows.push_back(d);
      m_bad = pbad;
    end else if (m_rows.size() == 0) begin
      e_sync = 1;
    end else begin
      m_rows.push_back(d);
      m_bad = m_bad | pbad;
    end
    if (m_rows.size() == ROWS) begin
`ifdef IMG_RX_PARITY_EN
      drop = m_bad;
`endif
      if (drop) begin
        e_par = 1;
        m_rows.delete();
      end else if (h) begin
        m_pend = 1;
      end else begin
        model_commit();
      end
    end
  endtask

  task automatic check_outputs();
    check("s_ready", s_ready, !m_pend);
    check("frame_upd", frame_upd, e_upd);
    check("err_sync", err_sync, e_sync);
    check("err_par", err_par, e_par);
    check("frame_cnt", frame_cnt, m_cnt);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("row%0d", r), frame_out[(ROWS-1-r)*ROW_W +: ROW_W], m_frame[r]);
    e_upd = 0; e_sync = 0; e_par = 0;
  endtask

  task automatic idle_cycle();
    s_valid = 0;
    s_data = $urandom; s_sof = 1'($urandom); s_par = 1'($urandom);
    if (!m_pend) hold = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic release_hold();
    // Garbage beats offered while parked must be ignored.
    repeat ($urandom_range(1, 3)) begin
      s_valid = 1; s_sof = 1; s_data = $urandom; s_par = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    hold = 0;
    @(posedge clk);
    model_commit();
    @(negedge clk);
    s_valid = 0;
    check_outputs();
  endtask

  task automatic send_beat(input logic [ROW_W-1:0] d, input bit sof, input bit pbad, input bit h);
    if (g_gaps) repeat ($urandom_range(0, 3) == 0 ? 1 : 0) idle_cycle();
    s_valid = 1; s_data = d; s_sof = sof; s_par = (^d) ^ pbad; hold = h;
    @(posedge clk);
    model_accept(d, sof, pbad, h);
    @(negedge clk);
    s_valid = 0; s_data = $urandom; s_sof = 1'($urandom); s_par = 1'($urandom);
    check_outputs();
    if (m_pend) release_hold();
  endtask

  task automatic send_frame(input int bad_at, input bit last_hold);
    for (int r = 0; r < ROWS; r++)
      send_beat($urandom, r == 0, r == bad_at, (r == ROWS-1) ? last_hold : 1'($urandom));
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1;
  endtask

  initial begin
    #5_000_000;
    n_errors++;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    m_total = 0;
    g_gaps = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;

    // Rows carry their own index.
    for (int r = 0; r < ROWS; r++) send_beat(ROW_W'(r), r == 0, 0, 0);
    check("row0_msbs", frame_out[1023:992], 0);
    check("row31_lsbs", frame_out[31:0], 31);
    idle_cycle();

    // Stray beat in IDLE.
    send_beat(32'hFFFF_FFFF, 0, 0, 0);
    idle_cycle();

    // Restart at row 10.
    for (int r = 0; r < 10; r++) send_beat($urandom, r == 0, 0, 0);
    send_beat(32'hA5A5_0F0F, 1, 0, 0);
    for (int r = 1; r < ROWS; r++) send_beat($urandom, 0, 0, 0);
    check("restart_row0", frame_out[1023:992], 32'hA5A5_0F0F);

    // Hold during last row.
    send_frame(-1, 1);

`ifdef IMG_RX_PARITY_EN
    send_frame(7, 0);
`endif

    // Reset at row 15, then a normal frame.
    for (int r = 0; r < 15; r++) send_beat($urandom, r == 0, 0, 0);
    async_reset();
    send_frame(-1, 0);

    // Randomized traffic until the frame counter has wrapped.
    g_gaps = 1;
    for (int f = 0; f < 400 && m_total < 280; f++) begin
      int abort_at;
      int bad_at;
      bit hl;
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, ROWS-1) : 0;
      bad_at   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, ROWS-1) : -1;
      hl       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) send_beat($urandom, 0, 0, 1'($urandom));
      for (int r = 0; r < abort_at; r++) send_beat($urandom, r == 0, 1'($urandom), 1'($urandom));
      send_frame(bad_at, hl);
    end
    check("wrapped", m_total >= (1 << CNT_W), 1);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
